uart_rx: RTL and testbench

//   Serial-to-parallel UART receiver; counterpart of the UART transmit path on the shared serial line.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_fsm.sv | 104 ++++++++++
 rtl/uart_rx.sv | 106 ++++++++++
 tb/tb_uart_rx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions (FSM encoding, frame geometry, parity
//             helper) used by both the receive and transmit paths.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  localparam int   DATA_BITS   = 8;
  localparam logic PARITY_EVEN = 1'b1;

  // Expected parity bit for a data byte under the configured parity sense.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return PARITY_EVEN ? (^d) : ~(^d);
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fsm
//  Purpose  : Receive sequencer. Owns the state register, bit index and bit
//             timer, and emits one-cycle strobes at each mid-bit sample point.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 5210
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_s,
  input  logic start_edge,
  output logic sample_data,
  output logic sample_parity,
  output logic sample_stop,
  output logic done
);

  localparam int             TW   = (BAUD_RATE > 1) ? $clog2(BAUD_RATE) : 1;
  localparam logic [TW-1:0]  HALF = TW'(BAUD_RATE / 2);
  localparam logic [TW-1:0]  LAST = TW'(BAUD_RATE - 1);
  localparam logic [TW-1:0]  ONE  = TW'(1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    idx;
  logic          at_half;
  logic          at_last;

  assign at_half = (timer == HALF);
  assign at_last = (timer == LAST);

  // Sequencing: the timer is zero on every state entry, so the first sample
  // lands at start+half and each later one a full bit period after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          idx   <= '0;
          if (start_edge) state <= ST_START;
        end
        ST_START: begin
          if (at_half) begin
            timer <= '0;
            // Line back high at mid-start means it was a glitch.
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + ONE;
          end
        end
        ST_DATA: begin
          if (at_last) begin
            timer <= '0;
            if (idx == 3'd7) state <= ST_PARITY;
            else             idx   <= idx + 3'd1;
          end else begin
            timer <= timer + ONE;
          end
        end
        ST_PARITY: begin
          if (at_last) begin
            timer <= '0;
            state <= ST_STOP;
          end else begin
            timer <= timer + ONE;
          end
        end
        ST_STOP: begin
          if (at_last) begin
            timer <= '0;
            state <= ST_DONE;
          end else begin
            timer <= timer + ONE;
          end
        end
        ST_DONE: begin
          timer <= '0;
          state <= ST_IDLE;
        end
        default: begin
          timer <= '0;
          idx   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sample_data   = (state == ST_DATA)   && at_last;
  assign sample_parity = (state == ST_PARITY) && at_last;
  assign sample_stop   = (state == ST_STOP)   && at_last;
  assign done          = (state == ST_DONE);

endmodule : uart_rx_fsm
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8E1 UART receiver. Synchronises the serial line, shifts in data
//             LSB first, and presents the byte with sticky status flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 5210
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 rx_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun
);

  logic                 sync1;
  logic                 rx_s;
  logic                 rx_d;
  logic [2:0]           fill;
  logic                 start_edge;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 stop_bit;
  logic                 sample_data;
  logic                 sample_parity;
  logic                 sample_stop;
  logic                 done;

  // Two-flop synchroniser plus one delay stage for edge detection. The fill
  // chain marks when rx_d holds a genuine line sample, so the preset-high
  // flops cannot fake a falling edge on a line that is low out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      fill  <= '0;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
      rx_d  <= rx_s;
      fill  <= {fill[1:0], 1'b1};
    end
  end

  assign start_edge = fill[2] & rx_d & ~rx_s;

  uart_rx_fsm #(
    .BAUD_RATE (BAUD_RATE)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .rx_s          (rx_s),
    .start_edge    (start_edge),
    .sample_data   (sample_data),
    .sample_parity (sample_parity),
    .sample_stop   (sample_stop),
    .done          (done)
  );

  // Capture mid-bit samples: data shifts in from the top so bit 0 ends at LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift      <= '0;
      parity_bit <= 1'b0;
      stop_bit   <= 1'b0;
    end else begin
      if (sample_data)   shift      <= {rx_s, shift[DATA_BITS-1:1]};
      if (sample_parity) parity_bit <= rx_s;
      if (sample_stop)   stop_bit   <= rx_s;
    end
  end

  // Holding register and sticky flags; a completing frame takes priority
  // over a simultaneous clear so its status is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (done) begin
      rx_data       <= shift;
      rx_ready      <= 1'b1;
      parity_error  <= (parity_bit != parity_of(shift));
      framing_error <= ~stop_bit;
      overrun       <= rx_ready;
    end else if (rx_clear) begin
      rx_ready      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end
  end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Directed self-checking bench for uart_rx at 16 clk per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b1;
  logic       rx_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .BAUD_RATE (BAUD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .rx_clear      (rx_clear),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  // Advance n clocks and settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    tick(BAUD);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    tick(1);
    rx_clear = 1'b0;
    tick(1);
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic rdy,
                         input logic pe, input logic fe, input logic ov);
    chk8({tag, ".data"}, rx_data, d);
    chk1({tag, ".ready"}, rx_ready, rdy);
    chk1({tag, ".perr"}, parity_error, pe);
    chk1({tag, ".ferr"}, framing_error, fe);
    chk1({tag, ".ovr"}, overrun, ov);
  endtask

  initial begin
    // Reset with the line held low; it must not start a frame afterwards.
    serial_in = 1'b0;
    rst = 1'b1;
    tick(5);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(200);
    chk1("low_from_reset.ready", rx_ready, 1'b0);
    chk1("low_from_reset.ferr", framing_error, 1'b0);
    serial_in = 1'b1;
    tick(20);
    chk1("idle.ready", rx_ready, 1'b0);

    // Clean frame, then clear keeps data.
    send_frame(8'hA5, 1'b0, 1'b1);
    chk_all("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();
    chk1("a5_clear.ready", rx_ready, 1'b0);
    chk8("a5_clear.data", rx_data, 8'hA5);

    // Wrong parity.
    send_frame(8'h01, 1'b0, 1'b1);
    chk_all("01_perr", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_clear();
    chk1("01_clear.perr", parity_error, 1'b0);

    // Stop bit low, then line recovers and a good frame follows.
    send_frame(8'h3C, 1'b0, 1'b0);
    chk_all("3c_ferr", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    serial_in = 1'b1;
    tick(BAUD);
    pulse_clear();
    chk1("3c_clear.ferr", framing_error, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    chk_all("55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // Short low glitch rejected; next frame received.
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    tick(3 * BAUD);
    chk1("glitch.ready", rx_ready, 1'b0);
    chk8("glitch.data", rx_data, 8'h55);
    send_frame(8'hF0, 1'b0, 1'b1);
    chk_all("f0", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clear();

    // Back-to-back frames without clearing -> overrun.
    send_frame(8'h11, 1'b0, 1'b1);
    chk_all("11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    chk_all("22_ovr", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-DATA of 0xFF (flags still set from previous frames).
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    tick(3);
    chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    serial_in = 1'b1;
    tick(2 * BAUD);
    chk1("post_rst.ready", rx_ready, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    chk_all("81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
